// File: rtl/io_map_pkg.sv
// Shared I/O window address map for the CPU data bus, plus switch-port decode helpers.
// Build option: SW_DEBOUNCE_EN (see sw_debounce) does not affect anything in this package.
package io_map_pkg;

  localparam int IO_LEDS_bit     = 2;
  localparam int IO_HEX_bit      = 3;
  localparam int IO_SW_STATE_bit = 4;
  localparam int IO_SW_EVENT_bit = 5;
  localparam int IO_SW_COUNT_bit = 6;
  localparam int IO_SPACE_bit    = 8;

  localparam int SW_COUNT_W = 16;

  typedef enum logic [1:0] {
    SW_SEL_NONE  = 2'd0,
    SW_SEL_STATE = 2'd1,
    SW_SEL_EVENT = 2'd2,
    SW_SEL_COUNT = 2'd3
  } swSel_e;

  // State beats event beats count when several select bits are set at once.
  function automatic swSel_e decodeSel(input logic isIO, input logic [2:0] selBits);
    swSel_e sel;
    sel = SW_SEL_NONE;
    if (isIO) begin
      if (selBits[0])      sel = SW_SEL_STATE;
      else if (selBits[1]) sel = SW_SEL_EVENT;
      else if (selBits[2]) sel = SW_SEL_COUNT;
    end
    return sel;
  endfunction

  // Expands per-byte store enables into a 32-bit bit mask.
  function automatic logic [31:0] byteMask(input logic [3:0] mask);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{mask[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch: 2-FF synchroniser, optional debounce counter, stable level and change pulse.
// Build option: SW_DEBOUNCE_EN enables the hold-time counter; otherwise stable follows the synchroniser.
// change_o is combinational and marks the edge on which stable_o will toggle.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sw_i,
  output logic stable_o,
  output logic change_o
);

  logic sync0_q;
  logic sync1_q;

  // Two-stage synchroniser for the asynchronous switch level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= sw_i;
      sync1_q <= sync0_q;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             change;

  // Count while the synchronised level disagrees; any agreement restarts the hold time.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    change   = 1'b0;
    if (sync1_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      change   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce counter and accepted level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign change_o = change;
`else
  // Without debounce the second sync stage is the stable level, so a change is
  // pending whenever the two stages disagree.
  logic unusedCfg;
  assign unusedCfg = (DEBOUNCE_CYCLES < 2);

  assign stable_o = sync1_q;
  assign change_o = sync0_q ^ sync1_q;
`endif

endmodule

// File: rtl/sw_input_port.sv
// Memory-mapped switch input port: per-switch debounce, sticky W1C change flags and a
// 16-bit change counter, all readable with one cycle of latency in the I/O window.
// Build option: SW_DEBOUNCE_EN (inside sw_debounce) selects debounced or raw-synchronised switches.
module sw_input_port
  import io_map_pkg::*;
#(
  parameter int NSW             = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [NSW-1:0]  sw_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     writedata_i,
  input  logic            memwrite_i,
  input  logic [3:0]      writemask_i,
  output logic [31:0]     readdata_o,
  output logic [NSW-1:0]  sw_stable_o
);

  logic [NSW-1:0]        swStable;
  logic [NSW-1:0]        changeVec;
  logic [31:0]           stateWord;
  logic [31:0]           changeWord;
  logic [31:0]           clearWord;
  logic                  anyChange;
  swSel_e                sel;
  logic                  eventStore;
  logic                  countStore;

  logic [31:0]           event_q, event_d;
  logic [SW_COUNT_W-1:0] count_q, count_d;
  logic [31:0]           readdata_q, readdata_d;

  logic unusedAddr;
  assign unusedAddr = ^{addr_i[31:9], addr_i[7], addr_i[3:0]};

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .sw_i     (sw_i[i]),
      .stable_o (swStable[i]),
      .change_o (changeVec[i])
    );
  end

  assign sel = decodeSel(addr_i[IO_SPACE_bit],
                         {addr_i[IO_SW_COUNT_bit], addr_i[IO_SW_EVENT_bit], addr_i[IO_SW_STATE_bit]});
  assign eventStore = memwrite_i && (sel == SW_SEL_EVENT);
  assign countStore = memwrite_i && (sel == SW_SEL_COUNT);
  assign anyChange  = |changeVec;
  assign clearWord  = eventStore ? (writedata_i & byteMask(writemask_i)) : 32'h0;

  // Widen per-switch vectors to the bus width; upper bits stay zero.
  always_comb begin
    stateWord            = '0;
    changeWord           = '0;
    stateWord[NSW-1:0]   = swStable;
    changeWord[NSW-1:0]  = changeVec;
  end

  // Next state for flags, counter and read data; new events override a same-cycle clear.
  always_comb begin
    event_d = (event_q & ~clearWord) | changeWord;
    count_d = count_q;
    if (countStore)     count_d = '0;
    else if (anyChange) count_d = count_q + 1'b1;
    readdata_d = 32'h0;
    case (sel)
      SW_SEL_STATE: readdata_d = stateWord;
      SW_SEL_EVENT: readdata_d = event_q;
      SW_SEL_COUNT: readdata_d = {{(32-SW_COUNT_W){1'b0}}, count_q};
      default:      readdata_d = 32'h0;
    endcase
  end

  // Register file and registered read port.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      event_q    <= '0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      event_q    <= event_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata_o  = readdata_q;
  assign sw_stable_o = swStable;

endmodule

// File: tb/tb_sw_input_port.sv
// Directed self-checking bench for sw_input_port with NSW=10, DEBOUNCE_CYCLES=4.
// Build option: SW_DEBOUNCE_EN selects the debounced expectations; without it the
// raw-synchronised path and counter wrap are exercised.
module tb_sw_input_port;

  localparam int NSW = 10;
  localparam int DC  = 4;
`ifdef SW_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
  localparam logic [31:0] EV_AFTER_GLITCH  = 32'h008;
  localparam logic [31:0] CNT_AFTER_GLITCH = 32'd1;
  localparam logic [31:0] EV_AFTER_W1C     = 32'h200;
  localparam logic [31:0] CNT_AFTER_SW9    = 32'd3;
  localparam logic [31:0] CNT_AFTER_PAIR   = 32'd4;
`else
  localparam int LAT = 2;
  localparam logic [31:0] EV_AFTER_GLITCH  = 32'h028;
  localparam logic [31:0] CNT_AFTER_GLITCH = 32'd3;
  localparam logic [31:0] EV_AFTER_W1C     = 32'h220;
  localparam logic [31:0] CNT_AFTER_SW9    = 32'd5;
  localparam logic [31:0] CNT_AFTER_PAIR   = 32'd6;
`endif

  logic           clk_i;
  logic           reset_i;
  logic [NSW-1:0] sw;
  logic [31:0]    addr;
  logic [31:0]    writedata;
  logic           memwrite;
  logic [3:0]     writemask;
  logic [31:0]    readdata;
  logic [NSW-1:0] swStable;

  int checks   = 0;
  int failures = 0;

  sw_input_port #(
    .NSW(NSW),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .sw_i        (sw),
    .addr_i      (addr),
    .writedata_i (writedata),
    .memwrite_i  (memwrite),
    .writemask_i (writemask),
    .readdata_o  (readdata),
    .sw_stable_o (swStable)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #1500000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Drive all inputs, then advance the given number of cycles and settle past the edge.
  task automatic applyStimulus(input logic [NSW-1:0] swVal, input logic [31:0] a,
                               input logic [31:0] wd, input logic we, input logic [3:0] m,
                               input int cycles);
    sw        = swVal;
    addr      = a;
    writedata = wd;
    memwrite  = we;
    writemask = m;
    repeat (cycles) @(posedge clk_i);
    #1;
    memwrite  = 1'b0;
    writemask = 4'h0;
    addr      = 32'h0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    sw        = '0;
    addr      = 32'h0;
    writedata = 32'h0;
    memwrite  = 1'b0;
    writemask = 4'h0;

    // Reset with all switches low.
    reset_i = 1'b1;
    applyStimulus(10'h000, 32'h0, 32'h0, 1'b0, 4'h0, 3);
    reset_i = 1'b0;
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_stable", {22'h0, swStable}, 32'h0);
    applyStimulus(10'h000, 32'h110, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("reset_state", readdata, 32'h0);
    applyStimulus(10'h000, 32'h120, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("reset_event", readdata, 32'h0);
    applyStimulus(10'h000, 32'h140, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("reset_count", readdata, 32'h0);

    // sw[3] rises: stable exactly LAT edges later.
    applyStimulus(10'h008, 32'h0, 32'h0, 1'b0, 4'h0, LAT - 1);
    checkOutput("sw3_early", {22'h0, swStable}, 32'h000);
    applyStimulus(10'h008, 32'h0, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("sw3_stable", {22'h0, swStable}, 32'h008);
    applyStimulus(10'h008, 32'h110, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("sw3_state", readdata, 32'h008);
    applyStimulus(10'h008, 32'h120, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("sw3_event", readdata, 32'h008);
    applyStimulus(10'h008, 32'h140, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("sw3_count", readdata, 32'h1);

`ifdef SW_DEBOUNCE_EN
    // Three-cycle glitch on sw[0] is rejected.
    applyStimulus(10'h009, 32'h0, 32'h0, 1'b0, 4'h0, 3);
    applyStimulus(10'h008, 32'h0, 32'h0, 1'b0, 4'h0, 10);
    checkOutput("glitch_stable", {22'h0, swStable}, 32'h008);
`else
    // One-cycle pulse on sw[5] passes straight through two cycles later.
    applyStimulus(10'h028, 32'h0, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("pulse_edge1", {22'h0, swStable}, 32'h008);
    applyStimulus(10'h008, 32'h0, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("pulse_edge2", {22'h0, swStable}, 32'h028);
    applyStimulus(10'h008, 32'h0, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("pulse_edge3", {22'h0, swStable}, 32'h008);
`endif
    applyStimulus(10'h008, 32'h120, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("glitch_event", readdata, EV_AFTER_GLITCH);
    applyStimulus(10'h008, 32'h140, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("glitch_count", readdata, CNT_AFTER_GLITCH);

    // sw[9] rises, then W1C of bit 3 with all bytes enabled.
    applyStimulus(10'h208, 32'h0, 32'h0, 1'b0, 4'h0, LAT);
    checkOutput("sw9_stable", {22'h0, swStable}, 32'h208);
    applyStimulus(10'h208, 32'h120, 32'h008, 1'b1, 4'hF, 1);
    applyStimulus(10'h208, 32'h120, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("w1c_bit3", readdata, EV_AFTER_W1C);

    // Clear of bit 9 lands on the same edge as its new event: set wins.
    applyStimulus(10'h008, 32'h0, 32'h0, 1'b0, 4'h0, LAT - 1);
    checkOutput("sw9_fall_early", {22'h0, swStable}, 32'h208);
    applyStimulus(10'h008, 32'h120, 32'h200, 1'b1, 4'h2, 1);
    checkOutput("sw9_fall", {22'h0, swStable}, 32'h008);
    applyStimulus(10'h008, 32'h120, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("w1c_set_wins", readdata, EV_AFTER_W1C);

    // Byte 1 disabled: bit 9 survives, everything else clears.
    applyStimulus(10'h008, 32'h120, 32'hFFFF_FFFF, 1'b1, 4'hD, 1);
    applyStimulus(10'h008, 32'h120, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("w1c_bytemask", readdata, 32'h200);

    // Store to the state register has no effect.
    applyStimulus(10'h008, 32'h110, 32'hFFFF_FFFF, 1'b1, 4'hF, 1);
    applyStimulus(10'h008, 32'h120, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("state_store_ignored", readdata, 32'h200);
    applyStimulus(10'h008, 32'h120, 32'h200, 1'b1, 4'h2, 1);
    applyStimulus(10'h008, 32'h120, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("w1c_bit9", readdata, 32'h0);
    applyStimulus(10'h008, 32'h140, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("count_sw9", readdata, CNT_AFTER_SW9);

    // sw[1] and sw[2] together count once.
    applyStimulus(10'h00E, 32'h0, 32'h0, 1'b0, 4'h0, LAT);
    checkOutput("pair_stable", {22'h0, swStable}, 32'h00E);
    applyStimulus(10'h00E, 32'h120, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("pair_event", readdata, 32'h006);
    applyStimulus(10'h00E, 32'h140, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("pair_count", readdata, CNT_AFTER_PAIR);

    // Any store to the count register clears it, even with no byte enables.
    applyStimulus(10'h00E, 32'h140, 32'h1234, 1'b1, 4'h0, 1);
    applyStimulus(10'h00E, 32'h140, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("count_clear", readdata, 32'h0);

    // Clear and increment on the same edge leave zero.
    applyStimulus(10'h00C, 32'h0, 32'h0, 1'b0, 4'h0, LAT - 1);
    applyStimulus(10'h00C, 32'h140, 32'h0, 1'b1, 4'h0, 1);
    checkOutput("clr_inc_stable", {22'h0, swStable}, 32'h00C);
    applyStimulus(10'h00C, 32'h140, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("clr_inc_count", readdata, 32'h0);

    // Read decode: unused I/O slots, non-I/O, and priority between select bits.
    applyStimulus(10'h00C, 32'h104, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("read_104", readdata, 32'h0);
    applyStimulus(10'h00C, 32'h108, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("read_108", readdata, 32'h0);
    applyStimulus(10'h00C, 32'h010, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("read_nonio", readdata, 32'h0);
    applyStimulus(10'h00C, 32'h130, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("read_prio_state", readdata, 32'h00C);
    applyStimulus(10'h00C, 32'h160, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("read_prio_event", readdata, 32'h006);

`ifndef SW_DEBOUNCE_EN
    // Toggle sw[0] every cycle to drive the count to 0xFFFF, then wrap it.
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(sw ^ 10'h001, 32'h0, 32'h0, 1'b0, 4'h0, 1);
    end
    applyStimulus(sw, 32'h0, 32'h0, 1'b0, 4'h0, 2);
    applyStimulus(sw, 32'h140, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("count_ffff", readdata, 32'h0000_FFFF);
    applyStimulus(sw ^ 10'h001, 32'h0, 32'h0, 1'b0, 4'h0, 2);
    applyStimulus(sw, 32'h140, 32'h0, 1'b0, 4'h0, 1);
    checkOutput("count_wrap", readdata, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
